// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Imported by mem_ctrl; holds the FSM encoding, length codes and the IO window tag.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_READ  = 2'd1,
    ST_LS_READ  = 2'd2,
    ST_LS_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  // Length code 3 is not a legal encoding and falls through to a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial bridge between the icache refill / load-store requesters and the
// external byte-wide RAM/IO bus, with IO back-pressure, flush and global freeze.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI_BITS = IO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [2:0]  len_n_reg, len_n_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] asm_reg, asm_next;
  logic        if_done_reg, if_done_next;
  logic        ls_done_reg, ls_done_next;
  logic [31:0] if_data_reg, if_data_next;
  logic [31:0] ls_rdata_reg, ls_rdata_next;

  logic [31:0] byte_addr;
  logic [31:0] sampled_word;
  logic [7:0]  wdata_lane [4];
  logic [3:0]  lane_hit;
  logic        sampling;
  logic        io_stall;
  logic        wr_strobe;

  assign byte_addr = addr_reg + {29'd0, cnt_reg};

  // In a read state the counter runs one ahead of the sample: cycle cnt issues
  // byte cnt while the byte issued at cnt-1 is arriving on mem_din.
  assign sampling = ((state_reg == ST_IF_READ) || (state_reg == ST_LS_READ)) &&
                    (cnt_reg != 3'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_lane[gi] = wdata_reg[8*gi +: 8];
      assign lane_hit[gi]   = sampling && (cnt_reg == 3'(gi + 1));
      assign sampled_word[8*gi +: 8] = lane_hit[gi] ? mem_din : asm_reg[8*gi +: 8];
    end
  endgenerate

  assign io_stall = (state_reg == ST_LS_WRITE) &&
                    (byte_addr[17:16] == IO_HI_BITS) && io_buffer_full;

  // Bus drive: address parks at zero whenever no byte is being issued.
  always_comb begin
    mem_a     = '0;
    mem_dout  = '0;
    wr_strobe = 1'b0;
    case (state_reg)
      ST_IF_READ, ST_LS_READ: begin
        if (cnt_reg < len_n_reg) begin
          mem_a = byte_addr;
        end
      end
      ST_LS_WRITE: begin
        mem_a     = byte_addr;
        mem_dout  = wdata_lane[cnt_reg[1:0]];
        wr_strobe = !io_stall;
      end
      default: ;
    endcase
  end

  assign mem_wr   = wr_strobe & rdy;
  assign if_done  = if_done_reg;
  assign ls_done  = ls_done_reg;
  assign if_data  = if_data_reg;
  assign ls_rdata = ls_rdata_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    len_n_next    = len_n_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    asm_next      = asm_reg;
    if_done_next  = 1'b0;
    ls_done_next  = 1'b0;
    if_data_next  = if_data_reg;
    ls_rdata_next = ls_rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        // A done pulse blocks acceptance so the requester's still-high req is not retaken.
        if (!clear && !if_done_reg && !ls_done_reg) begin
          if (ls_req) begin
            state_next = ls_wr ? ST_LS_WRITE : ST_LS_READ;
            addr_next  = ls_addr;
            wdata_next = ls_wdata;
            len_n_next = byte_count(ls_len);
            cnt_next   = 3'd0;
            asm_next   = '0;
          end else if (if_req) begin
            state_next = ST_IF_READ;
            addr_next  = if_addr;
            len_n_next = 3'd4;
            cnt_next   = 3'd0;
            asm_next   = '0;
          end
        end
      end

      ST_IF_READ, ST_LS_READ: begin
        if (clear) begin
          state_next = ST_IDLE;
          cnt_next   = 3'd0;
        end else begin
          asm_next = sampled_word;
          if (cnt_reg == len_n_reg) begin
            state_next = ST_IDLE;
            cnt_next   = 3'd0;
            if (state_reg == ST_IF_READ) begin
              if_done_next = 1'b1;
              if_data_next = sampled_word;
            end else begin
              ls_done_next  = 1'b1;
              ls_rdata_next = sampled_word;
            end
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end

      ST_LS_WRITE: begin
        // Stores are already committed, so a flush does not interrupt them.
        if (wr_strobe) begin
          if (cnt_reg == len_n_reg - 3'd1) begin
            state_next   = ST_IDLE;
            cnt_next     = 3'd0;
            ls_done_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 3'd0;
      len_n_reg    <= 3'd0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      asm_reg      <= '0;
      if_done_reg  <= 1'b0;
      ls_done_reg  <= 1'b0;
      if_data_reg  <= '0;
      ls_rdata_reg <= '0;
    end else if (rdy) begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      len_n_reg    <= len_n_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      asm_reg      <= asm_next;
      if_done_reg  <= if_done_next;
      ls_done_reg  <= ls_done_next;
      if_data_reg  <= if_data_next;
      ls_rdata_reg <= ls_rdata_next;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM on the bus plus a shadow memory
// and cycle-schedule model that predict completion timing, bus traffic and data.
module tb_mem_ctrl;

  localparam logic [1:0] IO_TAG = 2'b11;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, if_req, ls_req, ls_wr, io_buffer_full;
  logic [31:0] if_addr, ls_addr, ls_wdata, if_data, ls_rdata, mem_a;
  logic [1:0]  ls_len;
  logic [7:0]  mem_din, mem_dout;
  logic        if_done, ls_done, mem_wr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // bus_ram is what the DUT talks to; ref_ram is the bench's own expectation.
  logic [7:0] bus_ram [logic [31:0]];
  logic [7:0] ref_ram [logic [31:0]];

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_ram.exists(a) ? bus_ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
  endfunction

  function automatic void init_byte(input logic [31:0] a, input logic [7:0] d);
    bus_ram[a] = d;
    ref_ram[a] = d;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
    return w;
  endfunction

  function automatic bit rdy_at(input int cyc, input int f);
    return !(f > 0 && cyc >= f && cyc < f + 2);
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= bus_rd(mem_a);
      if (mem_wr) bus_ram[mem_a] = mem_dout;
    end
  end

  // Per-cycle observations of the last transfer, index = cycle after accept.
  logic [31:0] obs_a    [32];
  logic        obs_wr   [32];
  logic [7:0]  obs_dout [32];
  logic        obs_ifd  [32];
  logic        obs_lsd  [32];
  int          done_cyc;
  logic [31:0] done_data;
  logic        stray_done;
  logic        done_after;

  task automatic run_xfer(input bit use_if, input bit wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int clear_at, input int full_cycles,
                          input int freeze_at, input int rst_at);
    done_cyc   = -1;
    done_data  = '0;
    stray_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      obs_a[i] = '0; obs_wr[i] = 1'b0; obs_dout[i] = '0; obs_ifd[i] = 1'b0; obs_lsd[i] = 1'b0;
    end
    @(posedge clk); #1;
    if (use_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wdata;
    end
    for (int cyc = 1; cyc <= 24 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      clear          = (cyc == clear_at);
      rst            = (cyc == rst_at);
      io_buffer_full = (cyc <= full_cycles);
      rdy            = rdy_at(cyc, freeze_at);
      if ((cyc == clear_at && !wr) || cyc == rst_at) begin
        if_req = 1'b0; ls_req = 1'b0;
      end
      @(negedge clk);
      obs_a[cyc] = mem_a; obs_wr[cyc] = mem_wr; obs_dout[cyc] = mem_dout;
      obs_ifd[cyc] = if_done; obs_lsd[cyc] = ls_done;
      if (use_if ? if_done : ls_done) begin
        done_cyc  = cyc;
        done_data = use_if ? if_data : ls_rdata;
        if_req = 1'b0; ls_req = 1'b0;
      end
      if (use_if ? ls_done : if_done) stray_done = 1'b1;
    end
    @(posedge clk); #1;
    clear = 1'b0; rst = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    done_after = use_if ? if_done : ls_done;
    $display("xfer if=%0d wr=%0d len=%0d addr=%h wdata=%h done_cyc=%0d data=%h",
             use_if, wr, len, addr, wdata, done_cyc, done_data);
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    ls_len = 2'd0; if_addr = '0; ls_addr = '0; ls_wdata = '0; io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL reset mem_wr: got %b expected 0", mem_wr); end
    vectors++; if (mem_a !== 32'h0) begin miscompares++; $display("FAIL reset mem_a: got %h expected 0", mem_a); end
    vectors++; if (mem_dout !== 8'h0) begin miscompares++; $display("FAIL reset mem_dout: got %h expected 0", mem_dout); end
    vectors++; if ({if_done, ls_done} !== 2'b00) begin miscompares++; $display("FAIL reset done: got %b expected 00", {if_done, ls_done}); end
    vectors++; if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin miscompares++; $display("FAIL reset data: got %h/%h expected 0/0", if_data, ls_rdata); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_if_read;
    int wr_seen;
    init_byte(32'h1000, 8'h13); init_byte(32'h1001, 8'h05);
    init_byte(32'h1002, 8'h00); init_byte(32'h1003, 8'h00);
    run_xfer(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs_a[k+1] !== 32'h1000 + 32'(k)) begin miscompares++; $display("FAIL if_read mem_a c%0d: got %h expected %h", k+1, obs_a[k+1], 32'h1000 + 32'(k)); end
    end
    wr_seen = 0;
    for (int c = 0; c < 32; c++) if (obs_wr[c]) wr_seen++;
    vectors++; if (wr_seen != 0) begin miscompares++; $display("FAIL if_read mem_wr: got %0d writes expected 0", wr_seen); end
    vectors++; if (done_cyc != 6) begin miscompares++; $display("FAIL if_read latency: got %0d expected 6", done_cyc); end
    vectors++; if (done_data !== 32'h0000_0513) begin miscompares++; $display("FAIL if_read data: got %h expected 00000513", done_data); end
    vectors++; if (done_after !== 1'b0) begin miscompares++; $display("FAIL if_read pulse width: got %b expected 0", done_after); end
  endtask

  task automatic test_priority;
    int ls_cyc, if_cyc;
    logic [31:0] ls_val, if_val, exp_if;
    init_byte(32'h20, 8'hFF);
    exp_if = ref_word(32'h0, 4);
    ls_cyc = -1; if_cyc = -1; ls_val = '0; if_val = '0;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h0;
    for (int cyc = 1; cyc <= 20 && if_cyc < 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (ls_done && ls_cyc < 0) begin ls_cyc = cyc; ls_val = ls_rdata; ls_req = 1'b0; end
      if (if_done) begin if_cyc = cyc; if_val = if_data; if_req = 1'b0; end
    end
    @(posedge clk); #1; if_req = 1'b0; ls_req = 1'b0;
    $display("xfer priority ls_cyc=%0d ls_data=%h if_cyc=%0d if_data=%h", ls_cyc, ls_val, if_cyc, if_val);
    vectors++; if (ls_cyc != 3) begin miscompares++; $display("FAIL priority ls latency: got %0d expected 3", ls_cyc); end
    vectors++; if (ls_val !== 32'h0000_00FF) begin miscompares++; $display("FAIL priority ls data: got %h expected 000000ff", ls_val); end
    vectors++; if (if_cyc != 10) begin miscompares++; $display("FAIL priority if done cycle: got %0d expected 10", if_cyc); end
    vectors++; if (if_val !== exp_if) begin miscompares++; $display("FAIL priority if data: got %h expected %h", if_val, exp_if); end
  endtask

  task automatic test_store_half;
    logic [31:0] exp_w;
    run_xfer(1'b0, 1'b1, 2'd1, 32'h0000_0101, 32'h0000_BEEF, 0, 0, 0, 0);
    ref_ram[32'h101] = 8'hEF; ref_ram[32'h102] = 8'hBE;
    vectors++; if ({obs_wr[1], obs_a[1], obs_dout[1]} !== {1'b1, 32'h101, 8'hEF}) begin miscompares++; $display("FAIL store_half byte0: got wr=%b a=%h d=%h expected 1/00000101/ef", obs_wr[1], obs_a[1], obs_dout[1]); end
    vectors++; if ({obs_wr[2], obs_a[2], obs_dout[2]} !== {1'b1, 32'h102, 8'hBE}) begin miscompares++; $display("FAIL store_half byte1: got wr=%b a=%h d=%h expected 1/00000102/be", obs_wr[2], obs_a[2], obs_dout[2]); end
    vectors++; if (done_cyc != 3) begin miscompares++; $display("FAIL store_half latency: got %0d expected 3", done_cyc); end
    exp_w = ref_word(32'h100, 4);
    run_xfer(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 0, 0, 0);
    vectors++; if (done_data !== exp_w || done_data[23:8] !== 16'hBEEF) begin miscompares++; $display("FAIL store_half readback: got %h expected %h", done_data, exp_w); end
  endtask

  task automatic test_io_stall;
    int wr_seen;
    run_xfer(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 0, 3, 0, 0);
    ref_ram[32'h30000] = 8'h41;
    for (int c = 1; c <= 3; c++) begin
      vectors++; if (obs_wr[c] !== 1'b0) begin miscompares++; $display("FAIL io_stall wr c%0d: got %b expected 0", c, obs_wr[c]); end
    end
    vectors++; if ({obs_wr[4], obs_a[4], obs_dout[4]} !== {1'b1, 32'h30000, 8'h41}) begin miscompares++; $display("FAIL io_stall write: got wr=%b a=%h d=%h expected 1/00030000/41", obs_wr[4], obs_a[4], obs_dout[4]); end
    wr_seen = 0;
    for (int c = 0; c < 32; c++) if (obs_wr[c]) wr_seen++;
    vectors++; if (wr_seen != 1) begin miscompares++; $display("FAIL io_stall write count: got %0d expected 1", wr_seen); end
    vectors++; if (done_cyc != 5) begin miscompares++; $display("FAIL io_stall latency: got %0d expected 5", done_cyc); end
    vectors++; if (bus_rd(32'h30000) !== 8'h41) begin miscompares++; $display("FAIL io_stall ram: got %h expected 41", bus_rd(32'h30000)); end
  endtask

  task automatic test_clear;
    logic [31:0] exp_w;
    run_xfer(1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 3, 0, 0, 0);
    vectors++; if (done_cyc != -1) begin miscompares++; $display("FAIL clear_read done: got cycle %0d expected none", done_cyc); end
    vectors++; if (obs_a[4] !== 32'h0) begin miscompares++; $display("FAIL clear_read idle bus: got %h expected 0", obs_a[4]); end
    exp_w = ref_word(32'h204, 4);
    run_xfer(1'b1, 1'b0, 2'd2, 32'h0000_0204, 32'h0, 0, 0, 0, 0);
    vectors++; if (done_cyc != 6 || done_data !== exp_w) begin miscompares++; $display("FAIL clear_after read: got cyc=%0d data=%h expected 6/%h", done_cyc, done_data, exp_w); end
    run_xfer(1'b0, 1'b1, 2'd2, 32'h0000_0240, 32'h1234_5678, 2, 0, 0, 0);
    for (int k = 0; k < 4; k++) ref_ram[32'h240 + 32'(k)] = 8'(32'h1234_5678 >> (8*k));
    vectors++; if (done_cyc != 5) begin miscompares++; $display("FAIL clear_store latency: got %0d expected 5", done_cyc); end
    vectors++; if ({bus_rd(32'h243), bus_rd(32'h242), bus_rd(32'h241), bus_rd(32'h240)} !== 32'h1234_5678) begin miscompares++; $display("FAIL clear_store ram: got %h expected 12345678", {bus_rd(32'h243), bus_rd(32'h242), bus_rd(32'h241), bus_rd(32'h240)}); end
  endtask

  task automatic test_random;
    bit use_if, wr, bus_ok;
    logic [1:0] len;
    logic [31:0] addr, wdata, exp_data, a;
    int sel, n, full, freeze, k, cyc, exp_done, wr_seen;
    for (int t = 0; t < 40; t++) begin
      use_if = ($urandom_range(0, 2) == 0);
      wr     = use_if ? 1'b0 : 1'($urandom_range(0, 1));
      len    = use_if ? 2'd2 : 2'($urandom_range(0, 3));
      sel    = int'($urandom_range(0, 5));
      if (sel < 4) addr = 32'($urandom_range(0, 1023));
      else if (sel == 4) addr = 32'h0003_0000 + 32'($urandom_range(0, 255));
      else addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if (use_if) addr[1:0] = 2'b00;
      wdata  = $urandom;
      n      = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
      full   = int'($urandom_range(0, 3));
      freeze = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      exp_data = ref_word(addr, n);
      run_xfer(use_if, wr, len, addr, wdata, 0, full, freeze, 0);

      bus_ok = 1'b1; k = 0; cyc = 0;
      if (!wr) begin
        // A read needs n issue cycles plus one final sample cycle, all unfrozen.
        while (k < n + 1 && cyc < 30) begin
          cyc++;
          if (rdy_at(cyc, freeze)) begin
            if (k < n && obs_a[cyc] !== addr + 32'(k)) bus_ok = 1'b0;
            k++;
          end
        end
      end else begin
        // A byte is written on each unfrozen cycle not blocked by the IO buffer.
        while (k < n && cyc < 30) begin
          cyc++;
          a = addr + 32'(k);
          if (rdy_at(cyc, freeze) && !(a[17:16] == IO_TAG && cyc <= full)) begin
            if (obs_wr[cyc] !== 1'b1 || obs_a[cyc] !== a || obs_dout[cyc] !== wdata[8*k +: 8]) bus_ok = 1'b0;
            ref_ram[a] = wdata[8*k +: 8];
            k++;
          end else if (obs_wr[cyc] !== 1'b0) begin
            bus_ok = 1'b0;
          end
        end
      end
      exp_done = cyc + 1;
      wr_seen = 0;
      for (int c = 0; c < 32; c++) if (obs_wr[c]) wr_seen++;

      vectors++; if (done_cyc != exp_done) begin miscompares++; $display("FAIL rand%0d latency: got %0d expected %0d", t, done_cyc, exp_done); end
      vectors++; if (!bus_ok) begin miscompares++; $display("FAIL rand%0d bus sequence: got mismatching bus cycles expected clean sequence at %h", t, addr); end
      vectors++; if (wr_seen != (wr ? n : 0)) begin miscompares++; $display("FAIL rand%0d write count: got %0d expected %0d", t, wr_seen, wr ? n : 0); end
      vectors++; if (done_after !== 1'b0 || stray_done !== 1'b0) begin miscompares++; $display("FAIL rand%0d done pulse: got after=%b stray=%b expected 0/0", t, done_after, stray_done); end
      if (!wr) begin
        vectors++; if (done_data !== exp_data) begin miscompares++; $display("FAIL rand%0d read data: got %h expected %h", t, done_data, exp_data); end
      end else begin
        vectors++; if (ref_word(addr, 4) !== {bus_rd(addr + 32'd3), bus_rd(addr + 32'd2), bus_rd(addr + 32'd1), bus_rd(addr)}) begin
          miscompares++; $display("FAIL rand%0d ram: got %h expected %h", t, {bus_rd(addr + 32'd3), bus_rd(addr + 32'd2), bus_rd(addr + 32'd1), bus_rd(addr)}, ref_word(addr, 4));
        end
      end
    end
  endtask

  task automatic test_reset_mid_write;
    init_byte(32'h20, 8'hFF);
    run_xfer(1'b0, 1'b0, 2'd0, 32'h20, 32'h0, 0, 0, 0, 0);
    vectors++; if (ls_rdata !== 32'h0000_00FF) begin miscompares++; $display("FAIL rst_write preload: got %h expected 000000ff", ls_rdata); end
    run_xfer(1'b0, 1'b1, 2'd2, 32'h0000_0300, 32'hA1B2_C3D4, 0, 0, 0, 2);
    ref_ram[32'h300] = 8'hD4; ref_ram[32'h301] = 8'hC3;
    vectors++; if ({obs_wr[3], obs_a[3], obs_ifd[3], obs_lsd[3]} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL rst_write post-reset bus: got wr=%b a=%h ifd=%b lsd=%b expected 0/0/0/0", obs_wr[3], obs_a[3], obs_ifd[3], obs_lsd[3]); end
    vectors++; if (done_cyc != -1) begin miscompares++; $display("FAIL rst_write done: got cycle %0d expected none", done_cyc); end
    vectors++; if ({bus_rd(32'h303), bus_rd(32'h302), bus_rd(32'h301), bus_rd(32'h300)} !== ref_word(32'h300, 4)) begin miscompares++; $display("FAIL rst_write ram: got %h expected %h", {bus_rd(32'h303), bus_rd(32'h302), bus_rd(32'h301), bus_rd(32'h300)}, ref_word(32'h300, 4)); end
    vectors++; if (ls_rdata !== 32'h0 || if_data !== 32'h0) begin miscompares++; $display("FAIL rst_write data cleared: got %h/%h expected 0/0", ls_rdata, if_data); end
  endtask

  initial begin
    mem_din = 8'h00;
    for (int i = 0; i < 1024; i++) init_byte(32'(i), 8'($urandom));
    for (int i = 0; i < 256; i++) init_byte(32'h0003_0000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) init_byte(32'hFFFF_FFF0 + 32'(i), 8'($urandom));
    test_reset();
    test_if_read();
    test_priority();
    test_store_half();
    test_io_stall();
    test_clear();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
